// File: rtl/piso_pkg.sv
// piso_pkg: shared frame-state type and bit-order constants for the PISO serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel load handshake plus framed serial output of the PISO serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             p_valid;
  logic             p_ready;
  logic [WIDTH-1:0] p_data;
  logic             lsb_first;
  logic             shift_en;
  logic             s_data;
  logic             s_valid;
  logic             s_last;
  logic             busy;

  modport master (
    output p_valid, p_data, lsb_first, shift_en,
    input  p_ready, s_data, s_valid, s_last, busy
  );

  modport slave (
    input  p_valid, p_data, lsb_first, shift_en,
    output p_ready, s_data, s_valid, s_last, busy
  );
endinterface

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: frame bit counter with clear, enable and a terminal flag on the last data bit.
module piso_bit_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at WIDTH so the count never wraps inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(WIDTH))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit parallel-in serial-out serializer with zero-gap word streaming.
// Define PISO_PARITY_EN to append an even-parity bit (carrying s_last) to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  piso_serializer_if.slave bus
);
  state_e           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             order;
  logic             tc;
  logic             accept;
  logic             last_take;
  logic             ready_c;
  logic             cnt_en;
  logic             s_data_c;
  logic             s_valid_c;
  logic             s_last_c;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, load handshake and serial output decode.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    last_take = 1'b0;
    accept    = 1'b0;
    s_data_c  = 1'b0;
    s_valid_c = 1'b0;
    s_last_c  = 1'b0;
    case (state)
      IDLE: ready_c = 1'b1;
      SHIFT: begin
        s_valid_c = 1'b1;
        s_data_c  = (order == LSB_FIRST) ? shreg[0] : shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
        if (tc && bus.shift_en) state_nxt = PARITY;
`else
        s_last_c = tc;
        if (tc && bus.shift_en) begin
          ready_c   = 1'b1;
          last_take = 1'b1;
        end
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        s_valid_c = 1'b1;
        s_data_c  = par;
        s_last_c  = 1'b1;
        if (bus.shift_en) begin
          ready_c   = 1'b1;
          last_take = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (rst) ready_c = 1'b0;
    accept = ready_c && bus.p_valid;
    if (accept)         state_nxt = SHIFT;
    else if (last_take) state_nxt = IDLE;
  end

  assign cnt_en = (state == SHIFT) && bus.shift_en;

  // Shift toward whichever end is being presented, zero-filling behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      order <= MSB_FIRST;
    end else if (accept) begin
      shreg <= bus.p_data;
      order <= bus.lsb_first;
    end else if (cnt_en) begin
      shreg <= (order == LSB_FIRST) ? (shreg >> 1) : (shreg << 1);
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par <= 1'b0;
    else if (accept) par <= ^bus.p_data;
  end
`endif

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cnt_en),
    .tc  (tc)
  );

  assign bus.p_ready = ready_c;
  assign bus.s_data  = s_data_c;
  assign bus.s_valid = s_valid_c;
  assign bus.s_last  = s_last_c;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector table, directed corner sequences and a random run checked by a frame-queue model.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned FL = W + PB;

  typedef struct {
    logic [W-1:0] word;
    logic         lsb;
    logic [W-1:0] exp_bits;
    logic         exp_par;
    bit           stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   exp_q[$];
  bit   last_q[$];
  vec_t tbl[6];

  piso_serializer_if #(.WIDTH(W)) bus();
  piso_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word becomes a list of frame bits in transmission order.
  function automatic void push_frame(input logic [W-1:0] d, input logic lsb);
    for (int i = 0; i < int'(W); i++) begin
      exp_q.push_back(lsb ? d[i] : d[W-1-i]);
      last_q.push_back((PB == 0) && (i == int'(W) - 1));
    end
    if (PB != 0) begin
      exp_q.push_back(^d);
      last_q.push_back(1'b1);
    end
  endfunction

  // Consumer-side monitor: compares every cycle against the pending-bit queue.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_ready;
      if (rst) begin
        chk("mon_rst_outs", {bus.p_ready, bus.s_valid, bus.s_last, bus.busy, bus.s_data}, 64'd0);
        exp_q.delete();
        last_q.delete();
      end else begin
        exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && bus.shift_en);
        chk("mon_ready", bus.p_ready, exp_ready);
        chk("mon_valid", bus.s_valid, exp_q.size() != 0);
        chk("mon_busy", bus.busy, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("mon_data", bus.s_data, exp_q[0]);
          chk("mon_last", bus.s_last, last_q[0]);
          if (bus.shift_en) begin
            void'(exp_q.pop_front());
            void'(last_q.pop_front());
          end
        end else begin
          chk("mon_idle_data", {bus.s_data, bus.s_last}, 64'd0);
        end
        if (bus.p_valid && exp_ready) push_frame(bus.p_data, bus.lsb_first);
      end
    end
  end

  // Load one word from idle and collect its frame, optionally stalling every other cycle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [W-1:0] got;
    logic [15:0]  lasts;
    logic         par;
    int           n;
    int           guard;
    got = '0; lasts = '0; par = 1'b0; n = 0; guard = 0;
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_data = v.word; bus.lsb_first = v.lsb; bus.shift_en = 1'b0;
    #1 chk($sformatf("vec%0d_ready_idle", idx), bus.p_ready, 1'b1);
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    while (n < int'(FL) && guard < 4 * int'(FL)) begin
      bus.shift_en = v.stall ? (guard % 2 == 0) : 1'b1;
      @(negedge clk);
      if (bus.s_valid && bus.shift_en) begin
        if (n < int'(W)) got[W-1-n] = bus.s_data;
        else             par = bus.s_data;
        lasts[n] = bus.s_last;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.shift_en = 1'b0;
    chk($sformatf("vec%0d_count", idx), 64'(n), 64'(FL));
    chk($sformatf("vec%0d_bits", idx), got, v.exp_bits);
    chk($sformatf("vec%0d_last", idx), lasts, 16'(1) << (FL - 1));
    if (PB != 0) chk($sformatf("vec%0d_parity", idx), par, v.exp_par);
    chk($sformatf("vec%0d_idle_after", idx), bus.busy, 1'b0);
  endtask

  initial begin
    logic [31:0] stream;
    logic [31:0] exp_stream;
    logic [63:0] rdy_mask;
    int          vcnt;
    int          acc;

    tbl[0] = '{8'hB4, MSB_FIRST, 8'hB4, 1'b0, 1'b0};
    tbl[1] = '{8'hB4, LSB_FIRST, 8'h2D, 1'b0, 1'b1};
    tbl[2] = '{8'h07, MSB_FIRST, 8'h07, 1'b1, 1'b0};
    tbl[3] = '{8'h03, LSB_FIRST, 8'hC0, 1'b0, 1'b1};
    tbl[4] = '{8'h5A, LSB_FIRST, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{8'h81, MSB_FIRST, 8'h81, 1'b0, 1'b1};

    rst = 1'b1;
    bus.p_valid = 1'b1; bus.p_data = 8'h96; bus.lsb_first = MSB_FIRST; bus.shift_en = 1'b1;
    mon_en = 1'b1;

    // Reset hold with a word offered the whole time.
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", {bus.p_ready, bus.s_valid, bus.busy}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("first_ready", {bus.p_ready, bus.busy}, 64'b10);
    @(posedge clk); #1;
    chk("first_accept", {bus.busy, bus.s_valid, bus.s_data}, 64'b111);
    bus.p_valid = 1'b0;
    repeat (FL) @(posedge clk);
    #1 chk("first_done", bus.busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Back-to-back 8'hFF then 8'h00 with p_valid held.
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_data = 8'hFF; bus.lsb_first = MSB_FIRST; bus.shift_en = 1'b1;
    stream = '0; rdy_mask = '0; vcnt = 0; acc = 0;
    for (int c = 0; c <= 2 * int'(FL); c++) begin
      @(negedge clk);
      if (c >= 1) begin
        if (bus.s_valid) vcnt++;
        stream = {stream[30:0], bus.s_data};
        rdy_mask[c] = bus.p_ready;
      end
      if (bus.p_valid && bus.p_ready) acc++;
      @(posedge clk); #1;
      if (acc == 1) bus.p_data = 8'h00;
      if (acc == 2) bus.p_valid = 1'b0;
    end
    exp_stream = '0;
    for (int i = 0; i < int'(W); i++) exp_stream = (exp_stream << 1) | 32'd1;
    exp_stream = exp_stream << PB;
    exp_stream = exp_stream << FL;
    chk("b2b_valid_cnt", 64'(vcnt), 64'(2 * FL));
    chk("b2b_stream", stream, exp_stream);
    chk("b2b_ready_pulses", rdy_mask, (64'd1 << FL) | (64'd1 << (2 * FL)));
    chk("b2b_accepts", 64'(acc), 64'd2);
    bus.shift_en = 1'b0;

    // Mid-frame asynchronous reset after three bits of 8'hA5.
    @(posedge clk); #1;
    bus.p_valid = 1'b1; bus.p_data = 8'hA5; bus.lsb_first = MSB_FIRST;
    @(posedge clk); #1;
    bus.p_valid = 1'b0; bus.shift_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_outs", {bus.p_ready, bus.s_valid, bus.s_last, bus.busy, bus.s_data}, 64'd0);
    bus.shift_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("midrst_after", {bus.p_ready, bus.busy}, 64'b10);
    run_vec('{8'h3C, LSB_FIRST, 8'h3C, 1'b0, 1'b0}, 6);

    // Random traffic against the monitor model.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      bus.p_valid   = ($urandom_range(0, 2) != 0);
      bus.p_data    = W'($urandom);
      bus.lsb_first = 1'($urandom_range(0, 1));
      bus.shift_en  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.p_valid = 1'b0; bus.shift_en = 1'b1;
    repeat (2 * FL + 2) @(posedge clk);
    #1 chk("drain_idle", {bus.busy, bus.s_valid}, 64'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in serial-out serializer, the successor of the fixed 4-bit shift register. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, MSB-first or LSB-first selectable per word. Serial output carries valid and last-bit framing, and back-to-back words stream with no idle gap. It sits between a parallel datapath and a bit-serial link or test port.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- p_valid  in  1  parallel word offered
- p_ready  out  1  serializer can accept a word this cycle
- p_data  in  WIDTH  parallel word; captured on p_valid && p_ready
- lsb_first  in  1  bit order for the offered word; captured with p_data (0 = MSB first)
- shift_en  in  1  consume current serial bit and advance at this edge
- s_data  out  1  current serial bit
- s_valid  out  1  s_data holds a frame bit
- s_last  out  1  s_data is the final bit of the frame
- busy  out  1  a frame is in progress (state != IDLE)

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the parity option).
- Reset: state = IDLE, shift register = 0, bit count = 0, order flag = 0. s_data, s_valid, s_last and busy are 0. p_ready is forced 0 while rst is high.
- IDLE: p_ready = 1, s_valid = 0, s_data = 0. An accept (p_valid && p_ready) loads p_data and lsb_first, clears the count, and moves to SHIFT.
- SHIFT: s_valid = 1. s_data = shreg[WIDTH-1] when MSB-first, shreg[0] when LSB-first. Each edge with shift_en = 1 shifts the register toward the output end, zero-filled, and increments the count. With shift_en = 0 the register, count and outputs hold indefinitely.
- The final data bit is the one presented at count = WIDTH-1. When that bit is consumed:
  - with parity enabled, go to PARITY;
  - otherwise, go to SHIFT with a new word if an accept occurs in the same cycle, else go to IDLE.
- PARITY: s_data = the latched even-parity bit (XOR of the captured word), s_valid = 1, s_last = 1. Consuming it follows the same exit rule as above.
- p_ready is combinational: it is 1 in IDLE, and 1 when the final frame bit is presented with shift_en = 1. This gives zero-gap streaming. p_valid without p_ready is ignored, and the word is not captured.
- The bit count is $clog2(WIDTH+1) bits wide and never wraps within a frame.
- Asserting rst mid-frame aborts the frame immediately (asynchronous). There is no partial output after reset deasserts.

## Timing
- Accept at edge N: the first bit is valid on s_data after edge N, sampled by the consumer at edge N+1.
- A frame takes exactly WIDTH enabled cycles, or WIDTH+1 with parity. With shift_en held high and p_valid held high, the output is a continuous bit stream with s_valid never dropping.
- s_last asserts for the duration of the final bit only. With shift_en stalls it stays high until that bit is consumed.
- All outputs except p_ready are registered-state decodes. p_ready depends combinationally on shift_en.

## Configuration
- PISO_PARITY_EN defined: PARITY state is present. Each frame is WIDTH+1 bits, ending with the even-parity bit. s_last is on the parity bit only.
- PISO_PARITY_EN undefined: there is no PARITY state and no parity logic. Frames are WIDTH bits and s_last is on the final data bit.

## Structure
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT, PARITY);
  - bit-order constants MSB_FIRST = 0, LSB_FIRST = 1.
- One sub-module, piso_bit_cnt: parametrised up-counter with clear, enable and a terminal-count flag at WIDTH-1. It is instantiated once.

## Test plan
- Reset hold: rst high for 3 cycles with p_valid = 1 -> p_ready = 0, s_valid = 0, busy = 0 throughout. First accept occurs only after rst falls.
- MSB-first (WIDTH = 8): load 8'hB4 with lsb_first = 0 and shift_en = 1 -> s_data sequence 1,0,1,1,0,1,0,0, s_last on the 8th bit, then IDLE.
- LSB-first with stalls: load 8'hB4 with lsb_first = 1, shift_en toggling 1,0,1,0 -> sequence 0,0,1,0,1,1,0,1. Each bit holds during stall cycles and s_last holds across a stall.
- Back-to-back: p_valid constant with words 8'hFF then 8'h00 and shift_en = 1 -> 16 contiguous valid bits (eight 1s, eight 0s), p_ready pulses exactly on the last bit of each frame, and s_valid never drops.
- Parity (PISO_PARITY_EN): load 8'h07 -> 8 data bits, then parity bit 1 with s_last high. Load 8'h03 -> parity bit 0.
- Mid-frame reset: assert rst after 3 bits of 8'hA5 -> all outputs go to reset values immediately. Next load 8'h3C serializes fully and correctly.
